fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch-stage PC generator and IF/ID pipeline register for the dual-issue superscalar core.
- Each cycle it drives the fetch PC to the branch prediction unit's nextPC input and to instruction memory.
- It consumes the single fetch-time prediction (taken flag plus target) to choose the next PC.
- It accepts Memory-stage misprediction redirects, decode stalls and halt, and registers two fetch slots plus prediction info toward decode.

Parameters:
PC_WIDTH, 11, PC width in words; all PC arithmetic is modulo 2^PC_WIDTH
RESET_PC, 0, PC loaded on reset
CNT_WIDTH, 16, width of the saturating performance counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pred_taken_i  in  1  predictor taken flag for pred_pc_o (instMemPred)
pred_target_i  in  PC_WIDTH  predictor target for pred_pc_o (instMemTarget)
redirect_i  in  1  Memory-stage misprediction or redirect request
redirect_pc_i  in  PC_WIDTH  correct PC on redirect
stall_i  in  1  decode cannot accept; hold PC and IF/ID
halt_i  in  1  decode has seen a halt instruction
pred_pc_o  out  PC_WIDTH  current fetch PC to predictor nextPC (combinational = pc)
imem_addr0_o  out  PC_WIDTH  slot0 fetch address (= pc)
imem_addr1_o  out  PC_WIDTH  slot1 fetch address (= pc+1, wraps)
id_valid0_o, id_valid1_o  out  1 each  IF/ID slot valid
id_pc0_o, id_pc1_o  out  PC_WIDTH each  IF/ID slot PCs
id_pred_taken0_o  out  1  slot0 was predicted taken
id_pred_target0_o  out  PC_WIDTH  predicted next PC after slot0
halted_o  out  1  FSM is in HALTED
fetch_count_o  out  CNT_WIDTH  valid slots delivered, saturating
redirect_count_o  out  CNT_WIDTH  redirects taken, saturating

Behaviour:
- Reset (async, active-low):
  - pc = RESET_PC; FSM = BOOT.
  - All IF/ID fields = 0; counters = 0; halted_o = 0.
- FSM states:
  - BOOT: one cycle after reset release, no IF/ID write, PC held; then RUN. A redirect in BOOT is honoured and moves the FSM to RUN.
  - RUN: normal fetch.
  - HALTED: PC held, IF/ID valids 0, halted_o = 1. Left only on redirect_i, which goes to RUN.
- Prediction use in RUN: pred_use = pred_taken_i AND (pred_target_i != pc+1). A taken prediction with the default target (no BTB hit) is treated as not-taken.
- Priority each posedge, highest first:
  1. redirect_i: pc <= redirect_pc_i; both IF/ID valids <= 0 (overrides stall_i and halt_i); redirect_count += 1; FSM <= RUN.
  2. halt_i (RUN only): IF/ID valids <= 0; pc held; FSM <= HALTED.
  3. stall_i: pc and entire IF/ID held unchanged; no counter change.
  4. Advance (RUN):
     - id_pc0 <= pc; id_pc1 <= pc+1; id_valid0 <= 1.
     - id_valid1 <= NOT pred_use (slot1 is killed behind a predicted-taken slot0).
     - id_pred_taken0 <= pred_use.
     - id_pred_target0 <= pred_use ? pred_target_i : pc+2.
     - pc <= pred_use ? pred_target_i : pc+2.
     - fetch_count += (pred_use ? 1 : 2).
- Latency: one cycle from a PC being presented to its IF/ID appearance. A redirect produces its first valid IF/ID slot two posedges later.
- Slot1 is never predicted at fetch; decode-time prediction covers it.
- Wrap: pc+1 and pc+2 are taken modulo 2^PC_WIDTH. pc = 2047 gives imem_addr1 = 0 and next pc = 1.
- Counters saturate at all-ones. fetch_count saturates correctly even when +2 would overflow: 0xFFFE+2 -> 0xFFFF.
- The asynchronous reset in the middle of a stall, halt or redirect wins unconditionally.

Test Plan:
- Reset then release, no predictions taken:
  - BOOT cycle shows valids 0.
  - Next IF/ID shows pc0 = 0, pc1 = 1, both valid.
  - pc sequence is 0, 2, 4.
  - fetch_count = 2 after the first advance.
- At pc = 6 with pred_taken_i = 1, pred_target_i = 20:
  - IF/ID shows pc0 = 6, valid1 = 0, pred_taken0 = 1, target0 = 20.
  - Next pc = 20.
- At pc = 8 with pred_taken_i = 1, pred_target_i = 9: treated as not-taken; valid1 = 1 and next pc = 10.
- Redirect and stall asserted together, redirect_pc_i = 100:
  - IF/ID valids are 0 next cycle and pc = 100.
  - redirect_count = 1.
  - Then hold stall_i for 3 cycles and check that IF/ID and pc stay frozen.
- halt_i in RUN: halted_o = 1 and valids 0; pc is unchanged for 5 cycles. A later redirect to 40 resumes with pc0 = 40.
- Wrap and saturation:
  - Redirect to 2047: slots 2047 and 0, next pc = 1.
  - Force fetch_count to 0xFFFE, advance twice: count = 0xFFFF.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator and IF/ID pipeline register for the dual-issue core.
// Chooses the next PC from the fetch-time prediction, redirects, stalls and halt.
module fetch_pc_unit #(
   parameter int unsigned PC_WIDTH  = 11,
   parameter int unsigned RESET_PC  = 0,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pred_taken_i,
   input  logic [PC_WIDTH-1:0]  pred_target_i,
   input  logic                 redirect_i,
   input  logic [PC_WIDTH-1:0]  redirect_pc_i,
   input  logic                 stall_i,
   input  logic                 halt_i,
   output logic [PC_WIDTH-1:0]  pred_pc_o,
   output logic [PC_WIDTH-1:0]  imem_addr0_o,
   output logic [PC_WIDTH-1:0]  imem_addr1_o,
   output logic                 id_valid0_o,
   output logic                 id_valid1_o,
   output logic [PC_WIDTH-1:0]  id_pc0_o,
   output logic [PC_WIDTH-1:0]  id_pc1_o,
   output logic                 id_pred_taken0_o,
   output logic [PC_WIDTH-1:0]  id_pred_target0_o,
   output logic                 halted_o,
   output logic [CNT_WIDTH-1:0] fetch_count_o,
   output logic [CNT_WIDTH-1:0] redirect_count_o
);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED} state_t;

   state_t               r_state;
   logic [PC_WIDTH-1:0]  r_pc;
   logic                 r_valid0, r_valid1, r_pred_taken0, r_halted;
   logic [PC_WIDTH-1:0]  r_pc0, r_pc1, r_target0;
   logic [CNT_WIDTH-1:0] r_fetch_count, r_redirect_count;

   logic [PC_WIDTH-1:0]  w_pc_p1, w_pc_p2, w_next_pc;
   logic                 w_pred_use;
   logic [CNT_WIDTH:0]   w_fc_sum;
   logic [CNT_WIDTH-1:0] w_fc_next;

   assign w_pc_p1    = r_pc + PC_WIDTH'(1);
   assign w_pc_p2    = r_pc + PC_WIDTH'(2);
   // A taken prediction pointing at the fall-through slot is a BTB miss, not a branch.
   assign w_pred_use = pred_taken_i && (pred_target_i != w_pc_p1);
   assign w_next_pc  = w_pred_use ? pred_target_i : w_pc_p2;

   // One extra bit catches the +2 overflow so saturation still lands on all-ones.
   assign w_fc_sum  = {1'b0, r_fetch_count} + (w_pred_use ? (CNT_WIDTH+1)'(1) : (CNT_WIDTH+1)'(2));
   assign w_fc_next = w_fc_sum[CNT_WIDTH] ? '1 : w_fc_sum[CNT_WIDTH-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= ST_BOOT;
         r_pc             <= PC_WIDTH'(RESET_PC);
         r_valid0         <= 1'b0;
         r_valid1         <= 1'b0;
         r_pc0            <= '0;
         r_pc1            <= '0;
         r_pred_taken0    <= 1'b0;
         r_target0        <= '0;
         r_halted         <= 1'b0;
         r_fetch_count    <= '0;
         r_redirect_count <= '0;
      end else if (redirect_i) begin
         r_state  <= ST_RUN;
         r_pc     <= redirect_pc_i;
         r_valid0 <= 1'b0;
         r_valid1 <= 1'b0;
         r_halted <= 1'b0;
         if (r_redirect_count != '1)
            r_redirect_count <= r_redirect_count + CNT_WIDTH'(1);
      end else begin
         case (r_state)
            ST_BOOT: r_state <= ST_RUN;
            ST_RUN: begin
               if (halt_i) begin
                  r_state  <= ST_HALTED;
                  r_halted <= 1'b1;
                  r_valid0 <= 1'b0;
                  r_valid1 <= 1'b0;
               end else if (!stall_i) begin
                  r_pc0         <= r_pc;
                  r_pc1         <= w_pc_p1;
                  r_valid0      <= 1'b1;
                  r_valid1      <= !w_pred_use;
                  r_pred_taken0 <= w_pred_use;
                  r_target0     <= w_next_pc;
                  r_pc          <= w_next_pc;
                  r_fetch_count <= w_fc_next;
               end
            end
            default: begin
               r_valid0 <= 1'b0;
               r_valid1 <= 1'b0;
            end
         endcase
      end
   end

   assign pred_pc_o         = r_pc;
   assign imem_addr0_o      = r_pc;
   assign imem_addr1_o      = w_pc_p1;
   assign id_valid0_o       = r_valid0;
   assign id_valid1_o       = r_valid1;
   assign id_pc0_o          = r_pc0;
   assign id_pc1_o          = r_pc1;
   assign id_pred_taken0_o  = r_pred_taken0;
   assign id_pred_target0_o = r_target0;
   assign halted_o          = r_halted;
   assign fetch_count_o     = r_fetch_count;
   assign redirect_count_o  = r_redirect_count;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        pred_taken_i;
   logic [10:0] pred_target_i;
   logic        redirect_i;
   logic [10:0] redirect_pc_i;
   logic        stall_i;
   logic        halt_i;
   logic [10:0] pred_pc_o, imem_addr0_o, imem_addr1_o;
   logic        id_valid0_o, id_valid1_o;
   logic [10:0] id_pc0_o, id_pc1_o;
   logic        id_pred_taken0_o;
   logic [10:0] id_pred_target0_o;
   logic        halted_o;
   logic [15:0] fetch_count_o, redirect_count_o;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   fetch_pc_unit #(.PC_WIDTH(11), .RESET_PC(0), .CNT_WIDTH(16)) dut (
      .clk               (clk),
      .reset             (reset),
      .pred_taken_i      (pred_taken_i),
      .pred_target_i     (pred_target_i),
      .redirect_i        (redirect_i),
      .redirect_pc_i     (redirect_pc_i),
      .stall_i           (stall_i),
      .halt_i            (halt_i),
      .pred_pc_o         (pred_pc_o),
      .imem_addr0_o      (imem_addr0_o),
      .imem_addr1_o      (imem_addr1_o),
      .id_valid0_o       (id_valid0_o),
      .id_valid1_o       (id_valid1_o),
      .id_pc0_o          (id_pc0_o),
      .id_pc1_o          (id_pc1_o),
      .id_pred_taken0_o  (id_pred_taken0_o),
      .id_pred_target0_o (id_pred_target0_o),
      .halted_o          (halted_o),
      .fetch_count_o     (fetch_count_o),
      .redirect_count_o  (redirect_count_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; pred_taken_i = 1'b0; pred_target_i = '0;
      redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0; halt_i = 1'b0;
      #12;
      check_eq("rst_pc",     pred_pc_o, 0);
      check_eq("rst_v0",     id_valid0_o, 0);
      check_eq("rst_v1",     id_valid1_o, 0);
      check_eq("rst_fc",     fetch_count_o, 0);
      check_eq("rst_rc",     redirect_count_o, 0);
      check_eq("rst_halted", halted_o, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      step();  // BOOT
      check_eq("boot_v0", id_valid0_o, 0);
      check_eq("boot_pc", pred_pc_o, 0);

      step();
      check_eq("adv0_pc0", id_pc0_o, 0);
      check_eq("adv0_pc1", id_pc1_o, 1);
      check_eq("adv0_v0",  id_valid0_o, 1);
      check_eq("adv0_v1",  id_valid1_o, 1);
      check_eq("adv0_pc",  pred_pc_o, 2);
      check_eq("adv0_fc",  fetch_count_o, 2);
      step();
      check_eq("adv1_pc",  pred_pc_o, 4);
      check_eq("adv1_a1",  imem_addr1_o, 5);
      step();
      check_eq("adv2_pc",  pred_pc_o, 6);

      pred_taken_i = 1'b1; pred_target_i = 11'd20;
      step();
      pred_taken_i = 1'b0; pred_target_i = '0;
      check_eq("tk_pc0", id_pc0_o, 6);
      check_eq("tk_v1",  id_valid1_o, 0);
      check_eq("tk_pt0", id_pred_taken0_o, 1);
      check_eq("tk_tg0", id_pred_target0_o, 20);
      check_eq("tk_pc",  pred_pc_o, 20);
      check_eq("tk_fc",  fetch_count_o, 7);

      redirect_i = 1'b1; redirect_pc_i = 11'd100; stall_i = 1'b1;
      step();
      redirect_i = 1'b0;
      check_eq("rd_v0", id_valid0_o, 0);
      check_eq("rd_v1", id_valid1_o, 0);
      check_eq("rd_pc", pred_pc_o, 100);
      check_eq("rd_rc", redirect_count_o, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("stl_pc",  pred_pc_o, 100);
         check_eq("stl_v0",  id_valid0_o, 0);
         check_eq("stl_pc0", id_pc0_o, 6);
         check_eq("stl_fc",  fetch_count_o, 7);
      end
      stall_i = 1'b0;
      step();
      check_eq("post_pc0", id_pc0_o, 100);
      check_eq("post_pc",  pred_pc_o, 102);
      check_eq("post_fc",  fetch_count_o, 9);

      halt_i = 1'b1;
      step();
      halt_i = 1'b0;
      check_eq("hlt_h",  halted_o, 1);
      check_eq("hlt_v0", id_valid0_o, 0);
      check_eq("hlt_v1", id_valid1_o, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq("hlt_pc", pred_pc_o, 102);
         check_eq("hlt_hh", halted_o, 1);
      end
      check_eq("hlt_fc", fetch_count_o, 9);

      redirect_i = 1'b1; redirect_pc_i = 11'd40;
      step();
      redirect_i = 1'b0;
      check_eq("res_h",  halted_o, 0);
      check_eq("res_pc", pred_pc_o, 40);
      check_eq("res_rc", redirect_count_o, 2);
      step();
      check_eq("res_pc0", id_pc0_o, 40);
      check_eq("res_v0",  id_valid0_o, 1);

      redirect_i = 1'b1; redirect_pc_i = 11'd2047;
      step();
      redirect_i = 1'b0;
      check_eq("wr_pc", pred_pc_o, 2047);
      check_eq("wr_a1", imem_addr1_o, 0);
      step();
      check_eq("wr_pc0",  id_pc0_o, 2047);
      check_eq("wr_pc1",  id_pc1_o, 0);
      check_eq("wr_v1",   id_valid1_o, 1);
      check_eq("wr_next", pred_pc_o, 1);
      check_eq("wr_fc",   fetch_count_o, 13);

      // asynchronous reset lands mid-cycle while stalled
      stall_i = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check_eq("ar_pc", pred_pc_o, 0);
      check_eq("ar_v0", id_valid0_o, 0);
      check_eq("ar_fc", fetch_count_o, 0);
      check_eq("ar_rc", redirect_count_o, 0);
      step();
      stall_i = 1'b0;
      reset = 1'b1;
      step();  // BOOT
      for (int i = 0; i < 4; i++) step();
      check_eq("nt_pcb", pred_pc_o, 8);
      pred_taken_i = 1'b1; pred_target_i = 11'd9;
      step();
      pred_taken_i = 1'b0; pred_target_i = '0;
      check_eq("nt_v1",  id_valid1_o, 1);
      check_eq("nt_pt0", id_pred_taken0_o, 0);
      check_eq("nt_tg0", id_pred_target0_o, 10);
      check_eq("nt_pc",  pred_pc_o, 10);
      check_eq("nt_fc",  fetch_count_o, 10);

      for (int i = 0; i < 32762; i++) step();
      check_eq("sat_fe", fetch_count_o, 16'hFFFE);
      step();
      check_eq("sat_ff", fetch_count_o, 16'hFFFF);
      step();
      check_eq("sat_hold", fetch_count_o, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
